// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared panel geometry, SSD1331 command bytes, colours and streamer state type
// Optional power-up command list is compiled in with OLED_STREAMER_INIT_EN.
package oled_pkg;

  localparam int OLED_WIDTH  = 96;
  localparam int OLED_HEIGHT = 64;

  localparam int WINDOW_BYTES = 6;
  localparam int INIT_BYTES   = 8;

  localparam logic [7:0] CMD_SET_COLUMN   = 8'h15;
  localparam logic [7:0] CMD_SET_ROW      = 8'h75;
  localparam logic [7:0] CMD_DISPLAY_OFF  = 8'hAE;
  localparam logic [7:0] CMD_REMAP        = 8'hA0;
  localparam logic [7:0] CMD_REMAP_ARG    = 8'h72;
  localparam logic [7:0] CMD_START_LINE   = 8'hA1;
  localparam logic [7:0] CMD_DISP_OFFSET  = 8'hA2;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'hAF;

  localparam logic [15:0] RGB_BLACK  = 16'h0000;
  localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
  localparam logic [15:0] RGB_RED    = 16'hF800;
  localparam logic [15:0] RGB_GREEN  = 16'h07E0;
  localparam logic [15:0] RGB_BLUE   = 16'h001F;
  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WINDOW,
    ST_PIXEL,
    ST_GAP
  } stream_state_t;

`ifdef OLED_STREAMER_INIT_EN
  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return CMD_DISPLAY_OFF;
      3'd1:    return CMD_REMAP;
      3'd2:    return CMD_REMAP_ARG;
      3'd3:    return CMD_START_LINE;
      3'd4:    return 8'h00;
      3'd5:    return CMD_DISP_OFFSET;
      3'd6:    return 8'h00;
      default: return CMD_DISPLAY_ON;
    endcase
  endfunction
`endif

endpackage

// File: rtl/oled_spi_byte_tx.sv
// rtl/oled_spi_byte_tx.sv - MSB-first SPI byte shifter, sclk idles high, data changes on falling edge
module oled_spi_byte_tx #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       dc_in,
  output logic       sclk,
  output logic       sdin,
  output logic       d_cn,
  output logic       done
);

  logic       active;
  logic [7:0] div_cnt;
  logic [2:0] bit_cnt;
  logic [6:0] shreg;
  logic       half_end;

  assign half_end = active && (div_cnt == 8'(CLK_DIV - 1));
  // Combinational so a new start in this cycle lands on the very edge the byte ends.
  assign done     = half_end && sclk && (bit_cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      div_cnt <= 8'd0;
      bit_cnt <= 3'd0;
      shreg   <= 7'd0;
      sclk    <= 1'b1;
      sdin    <= 1'b0;
      d_cn    <= 1'b0;
    end else if (start) begin
      active  <= 1'b1;
      div_cnt <= 8'd0;
      bit_cnt <= 3'd0;
      shreg   <= byte_in[6:0];
      sclk    <= 1'b0;
      sdin    <= byte_in[7];
      d_cn    <= dc_in;
    end else if (done) begin
      active  <= 1'b0;
      div_cnt <= 8'd0;
      sdin    <= 1'b0;
      d_cn    <= 1'b0;
    end else if (half_end) begin
      div_cnt <= 8'd0;
      if (!sclk) begin
        sclk <= 1'b1;
      end else begin
        sclk    <= 1'b0;
        sdin    <= shreg[6];
        shreg   <= {shreg[5:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end else if (active) begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/oled_pixel_streamer.sv
// rtl/oled_pixel_streamer.sv - row-major pixel scan and SPI stream to the SSD1331; OLED_STREAMER_INIT_EN adds a one-shot init list
module oled_pixel_streamer
  import oled_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int WIDTH   = OLED_WIDTH,
  parameter int HEIGHT  = OLED_HEIGHT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] oled_data,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic        frame_begin,
  output logic        busy,
  output logic        cs,
  output logic        sclk,
  output logic        sdin,
  output logic        d_cn
);

  stream_state_t state, state_nxt;
  logic       cs_nxt;
  logic [2:0] idx, idx_nxt;
  logic [7:0] pix_lo;
  logic       lo_pending;
  logic [8:0] gap_cnt;
  logic       latch;
  logic       tx_start, tx_dc, tx_done;
  logic [7:0] tx_byte;
`ifdef OLED_STREAMER_INIT_EN
  logic       init_done;
`endif

  function automatic logic [7:0] window_cmd(input logic [2:0] i);
    case (i)
      3'd0:    return CMD_SET_COLUMN;
      3'd1:    return 8'h00;
      3'd2:    return 8'(WIDTH - 1);
      3'd3:    return CMD_SET_ROW;
      3'd4:    return 8'h00;
      default: return 8'(HEIGHT - 1);
    endcase
  endfunction

  oled_spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk     (clk),
    .reset   (reset),
    .start   (tx_start),
    .byte_in (tx_byte),
    .dc_in   (tx_dc),
    .sclk    (sclk),
    .sdin    (sdin),
    .d_cn    (d_cn),
    .done    (tx_done)
  );

  assign busy        = (state != ST_IDLE);
  assign frame_begin = latch && (x == 7'd0) && (y == 6'd0);

  always_comb begin
    state_nxt = state;
    cs_nxt    = cs;
    idx_nxt   = idx;
    tx_start  = 1'b0;
    tx_byte   = 8'h00;
    tx_dc     = 1'b0;
    latch     = 1'b0;
    case (state)
      ST_IDLE: if (enable) begin
        tx_start  = 1'b1;
        cs_nxt    = 1'b0;
        idx_nxt   = 3'd0;
        state_nxt = ST_WINDOW;
        tx_byte   = window_cmd(3'd0);
`ifdef OLED_STREAMER_INIT_EN
        if (!init_done) begin
          state_nxt = ST_INIT;
          tx_byte   = init_cmd(3'd0);
        end
`endif
      end
`ifdef OLED_STREAMER_INIT_EN
      ST_INIT: if (tx_done) begin
        tx_start = 1'b1;
        if (idx == 3'(INIT_BYTES - 1)) begin
          state_nxt = ST_WINDOW;
          idx_nxt   = 3'd0;
          tx_byte   = window_cmd(3'd0);
        end else begin
          idx_nxt = idx + 3'd1;
          tx_byte = init_cmd(idx + 3'd1);
        end
      end
`endif
      ST_WINDOW: if (tx_done) begin
        tx_start = 1'b1;
        if (idx == 3'(WINDOW_BYTES - 1)) begin
          state_nxt = ST_PIXEL;
          latch     = 1'b1;
          tx_byte   = oled_data[15:8];
          tx_dc     = 1'b1;
        end else begin
          idx_nxt = idx + 3'd1;
          tx_byte = window_cmd(idx + 3'd1);
        end
      end
      ST_PIXEL: if (tx_done) begin
        if (lo_pending) begin
          tx_start = 1'b1;
          tx_byte  = pix_lo;
          tx_dc    = 1'b1;
        end else if (x == 7'd0 && y == 6'd0) begin
          // Counters have wrapped: the final pixel just finished shifting.
          state_nxt = ST_GAP;
          cs_nxt    = 1'b1;
        end else begin
          tx_start = 1'b1;
          latch    = 1'b1;
          tx_byte  = oled_data[15:8];
          tx_dc    = 1'b1;
        end
      end
      ST_GAP: if (gap_cnt == 9'(2 * CLK_DIV - 1)) begin
        if (enable) begin
          state_nxt = ST_WINDOW;
          cs_nxt    = 1'b0;
          idx_nxt   = 3'd0;
          tx_start  = 1'b1;
          tx_byte   = window_cmd(3'd0);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cs         <= 1'b1;
      idx        <= 3'd0;
      x          <= 7'd0;
      y          <= 6'd0;
      pix_lo     <= 8'h00;
      lo_pending <= 1'b0;
      gap_cnt    <= 9'd0;
`ifdef OLED_STREAMER_INIT_EN
      init_done  <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      cs      <= cs_nxt;
      idx     <= idx_nxt;
      gap_cnt <= (state == ST_GAP) ? gap_cnt + 9'd1 : 9'd0;
      if (latch) begin
        lo_pending <= 1'b1;
        pix_lo     <= oled_data[7:0];
        if (x == 7'(WIDTH - 1)) begin
          x <= 7'd0;
          y <= (y == 6'(HEIGHT - 1)) ? 6'd0 : y + 6'd1;
        end else begin
          x <= x + 7'd1;
        end
      end else if (tx_start) begin
        lo_pending <= 1'b0;
      end
`ifdef OLED_STREAMER_INIT_EN
      if (state == ST_INIT && state_nxt == ST_WINDOW) init_done <= 1'b1;
`endif
    end
  end

endmodule

// File: doc/oled_pixel_streamer.md
# oled_pixel_streamer

- Transmit side of the pixel interface that the combinational screen renderers (menu, controls and game pages) feed.
- Scans the 96x64 panel in row-major order and presents `x`/`y` to the selected renderer.
- Samples the returned 16-bit RGB565 `oled_data` and serialises it, plus per-frame window commands, over 4-wire SPI to the SSD1331 PmodOLEDrgb.
- Sits between the page mux and the top-level Pmod pins.

## Interface
Parameters:
- `CLK_DIV`, default 2: half-period of SCLK in `clk` cycles; legal range 1-255.
- `WIDTH`, default 96: pixel columns.
- `HEIGHT`, default 64: pixel rows.

Ports:
- `clk` in 1: system clock; one clock domain only.
- `reset` in 1: reset is synchronous and active-high.
- `enable` in 1: level; start or continue streaming frames.
- `oled_data` in 16: RGB565 colour from the renderer for the current `x`,`y`.
- `x` out 7: column being requested, 0..WIDTH-1.
- `y` out 6: row being requested, 0..HEIGHT-1.
- `frame_begin` out 1: one-cycle pulse when pixel (0,0) is sampled.
- `busy` out 1: high whenever the state is not IDLE.
- `cs` out 1: SPI chip select, active low.
- `sclk` out 1: SPI clock.
- `sdin` out 1: SPI data.
- `d_cn` out 1: 0 = command byte, 1 = data byte.

## Operation
States: IDLE, INIT (macro only), WINDOW, PIXEL, GAP.

- **IDLE**
  - Outputs held at reset values.
  - When `enable`=1, go to INIT (if first frame after reset and the macro is defined), otherwise to WINDOW.
- **INIT**: shift the fixed command list with `d_cn`=0 (see Configuration), then go to WINDOW.
- **WINDOW**
  - Shift 6 command bytes with `d_cn`=0: 0x15, 0x00, WIDTH-1, 0x75, 0x00, HEIGHT-1.
  - Then go to PIXEL.
- **PIXEL**
  - Per pixel: latch `oled_data`, shift the high byte then the low byte, `d_cn`=1.
  - On the latch edge, advance `x`/`y`:
    - `x` wraps WIDTH-1 -> 0 and increments `y`.
    - `y` wraps HEIGHT-1 -> 0.
  - After pixel (WIDTH-1,HEIGHT-1) is shifted, go to GAP.
- **GAP**
  - `cs`=1 for exactly 2*CLK_DIV cycles.
  - Then WINDOW if `enable`=1, else IDLE.
- SPI format:
  - MSB first.
  - `sclk` idles high.
  - `sdin` and `d_cn` change on the `sclk` falling edge; the panel samples on the rising edge.
  - `cs` is low continuously from the first byte of WINDOW (or INIT) through the last pixel byte.
  - Bytes are back-to-back with no idle bits.
- Dropping `enable` mid-frame has no effect until the frame completes; transitions to IDLE happen only from GAP.
- `x`/`y` width rule: counters are exactly 7 and 6 bits with explicit compare-and-wrap; no reliance on natural overflow.

## Timing
- Reset values:
  - `cs`=1, `sclk`=1, `sdin`=0, `d_cn`=0.
  - `x`=0, `y`=0.
  - `frame_begin`=0, `busy`=0.
  - State IDLE, init-done flag cleared.
- `reset` mid-transfer aborts on the next edge: all outputs take their reset values, and no partial byte completes.
- Bit time = 2*CLK_DIV cycles; byte = 16*CLK_DIV; pixel = 32*CLK_DIV.
- Frame length from first WINDOW cycle to GAP entry = (6 + 2*WIDTH*HEIGHT)*16*CLK_DIV cycles. For the defaults this is 393408 cycles.
- The IDLE->WINDOW decision takes 1 cycle: `cs` falls the cycle after `enable` is first seen high.
- Renderer contract:
  - `oled_data` is sampled on the same edge `x`/`y` advance.
  - The renderer therefore has 32*CLK_DIV-1 cycles to settle for the next coordinate.
  - The renderer must be combinational or at most 1 cycle registered.
- `frame_begin` is high for exactly the one cycle in which pixel (0,0) is latched.

## Configuration
- Macro `OLED_STREAMER_INIT_EN`.
- Defined:
  - After the first `enable` following reset, the streamer sends INIT before the first WINDOW.
  - INIT is 8 command bytes: 0xAE, 0xA0, 0x72, 0xA1, 0x00, 0xA2, 0x00, 0xAF.
  - INIT costs 128*CLK_DIV cycles.
  - INIT is never repeated until the next `reset`.
- Undefined: the INIT state and command ROM are absent, and streaming starts directly at WINDOW (panel initialised elsewhere).

## Structure
- Shared package `oled_pkg`:
  - WIDTH/HEIGHT defaults.
  - Command byte constants (window and init list).
  - State enum.
  - RGB565 colour constants used by the renderers.
- One sub-module: `oled_spi_byte_tx`.
  - Ports: `start`, `byte_in[7:0]`, `dc_in` -> `sclk`, `sdin`, `d_cn`, `done` (1-cycle pulse after the last rising `sclk` half-period).
  - Accepts `start` in the same cycle as `done`, giving back-to-back bytes.
- The top FSM owns the counters, `cs` and the byte sequencing.

## Test plan
- Reset then `enable`=1, CLK_DIV=2, renderer returns 0xF800 -> `cs` falls in the next cycle; decoded bytes are 0x15,0x00,0x5F,0x75,0x00,0x3F; then 6144 pairs 0xF8,0x00 with `d_cn`=1; `cs` rises at cycle 393408.
- Renderer drives `oled_data`={x,y,3'b0} -> the decoded pixel sequence matches row-major order (0,0)..(95,0),(0,1)..(95,63), with one `frame_begin` pulse per frame.
- `enable` dropped at pixel (10,5) -> the frame completes to (95,63), GAP lasts 4 cycles, then IDLE with `busy`=0.
- `reset` asserted mid-byte -> the next cycle shows `cs`=1, `sclk`=1, `x`=`y`=0; after release the first decoded byte is 0x15, or 0xAE with the macro defined.
- With `OLED_STREAMER_INIT_EN`, two consecutive frames -> INIT bytes appear only before frame 1; without the macro, the first byte is 0x15.
